// File: rtl/adder_seq_pkg.sv
// ----------------------------------------------------------------------------
// adder_seq_pkg
// Shared constants and types for the slice-serial adder sequencer.
//   SLICE_W : width of the shared ripple-carry slice (bits per iteration)
//   state_t : sequencer states (IDLE -> RUN -> DONE -> IDLE)
// No ports (package).
// ----------------------------------------------------------------------------
package adder_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : adder_seq_pkg

// File: rtl/add_slice4.sv
// ----------------------------------------------------------------------------
// add_slice4
// Purely combinational 4-bit ripple-carry adder slice built from a chain of
// full-adder cells.
// Ports:
//   x, y   : 4-bit addends
//   cin    : carry into bit 0
//   s      : 4-bit sum
//   cout   : carry out of bit 3
// ----------------------------------------------------------------------------
module add_slice4
    import adder_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    // c[i] is the carry into bit i; c[SLICE_W] leaves the slice.
    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        // Full-adder cell: half-adder on x/y, second half-adder with carry-in.
        logic hs;
        logic hc;
        assign hs       = x[i] ^ y[i];
        assign hc       = x[i] & y[i];
        assign s[i]     = hs ^ c[i];
        assign c[i + 1] = hc | (hs & c[i]);
    end

    assign cout = c[SLICE_W];

endmodule : add_slice4

// File: rtl/adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// adder_seq_ctrl
// Adds two WIDTH-bit operands one 4-bit slice per clock through a single
// shared add_slice4, holding the inter-slice carry in a register.
//
// Optional feature macro: ADDSUB_EN
//   defined   -> extra input 'sub'; sub=1 computes a-b (mod 2^WIDTH) and
//                carry_out=1 means no borrow (a >= b unsigned).
//   undefined -> add only, no 'sub' port.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a/b (and sub) valid
//   in_ready   : sequencer can accept operands (high only in IDLE)
//   a, b       : WIDTH-bit operands
//   sub        : (ADDSUB_EN only) subtract select, sampled with a/b
//   out_valid  : sum/carry_out valid (high only in DONE)
//   out_ready  : consumer accepts result
//   sum        : registered result, modulo 2^WIDTH
//   carry_out  : registered carry out of the MSB slice
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. On the input side operands are captured only in IDLE; in_valid
// seen in RUN/DONE is ignored and the producer must hold its request. On the
// output side out_valid, sum and carry_out stay stable until out_ready is
// seen, and sum/carry_out keep the last result after the transfer.
// ----------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDSUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("adder_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state;
    state_t             state_next;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic [WIDTH-1:0]   sum_sh_next;
    logic               carry;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;

    logic               accept;
    logic               last;

    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic               start_carry;

    // ------------------------------------------------------------------
    // Add/subtract selection. Subtraction is a + ~b + 1: invert every
    // slice of b and seed the carry chain with 1.
    // ------------------------------------------------------------------
`ifdef ADDSUB_EN
    logic sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end

    assign slice_b     = sub_q ? ~b_sh[SLICE_W-1:0] : b_sh[SLICE_W-1:0];
    assign start_carry = sub;
`else
    assign slice_b     = b_sh[SLICE_W-1:0];
    assign start_carry = 1'b0;
`endif

    add_slice4 u_slice (
        .x    (a_sh[SLICE_W-1:0]),
        .y    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_c)
    );

    // Slices arrive LSB first and are shifted in from the top, so after
    // NSLICE iterations the first slice has reached bit 0.
    if (NSLICE == 1) begin : g_one_slice
        assign sum_sh_next = slice_s;
    end else begin : g_multi_slice
        assign sum_sh_next = {slice_s, sum_sh[WIDTH-1:SLICE_W]};
    end

    assign last = (idx == IDX_W'(NSLICE - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= start_carry;
                idx   <= '0;
            end else if (state == RUN) begin
                a_sh   <= a_sh >> SLICE_W;
                b_sh   <= b_sh >> SLICE_W;
                sum_sh <= sum_sh_next;
                carry  <= slice_c;
                if (last) begin
                    // Publish the finished result; it is held from here
                    // through DONE and the following IDLE.
                    sum_r  <= sum_sh_next;
                    cout_r <= slice_c;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign sum       = sum_r;
    assign carry_out = cout_r;

endmodule : adder_seq_ctrl

// File: tb/tb_adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Self-checking bench for adder_seq_ctrl (WIDTH=16). Directed vectors from a
// table, hand-written sequences for backpressure, busy-input and mid-operation
// reset, then randomized operations against a plain-arithmetic model.
// Build with +define+ADDSUB_EN to also exercise subtraction.
// ----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub_drv;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;

    int checks;
    int failures;

    // Scoreboard entries are {carry_out, sum}.
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vs;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    adder_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef ADDSUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: unsigned add with carry past bit W-1, or unsigned subtract
    // where carry means "no borrow".
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        longint unsigned total;
        logic [W-1:0]    diff;
        if (s) begin
            diff = x - y;
            return {(x >= y), diff};
        end
        total = longint'(x) + longint'(y);
        return {(total > longint'(2 ** W - 1)), total[W-1:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation and check it against the head of exp_q.
    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vs, input int bp, input bit poke);
        int         k;
        logic [W:0] exp;
        exp = '0;
        a        = va;
        b        = vb;
        sub_drv  = vs;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();                     // accept edge T0
        in_valid = 1'b0;
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        check("out_valid_in_run", 32'(out_valid), 32'd0);

        k = 0;
        while (!out_valid && k < NS + 6) begin
            step();
            k++;
            if (poke && k == 1) begin
                in_valid = 1'b1;
                a        = 16'h1234;
                b        = 16'h4321;
            end else if (poke && k == 2) begin
                in_valid = 1'b0;
                a        = va;
                b        = vb;
            end
            if (!out_valid) begin
                check("in_ready_busy", 32'(in_ready), 32'd0);
            end
        end
        check("out_valid_timeout", 32'(out_valid), 32'd1);
        check("latency", 32'(k), 32'(NS));

        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
        end
        check("sum", 32'(sum), 32'(exp[W-1:0]));
        check("carry_out", 32'(carry_out), 32'(exp[W]));
        check("in_ready_done", 32'(in_ready), 32'd0);

        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_sum", 32'(sum), 32'(exp[W-1:0]));
            check("bp_carry", 32'(carry_out), 32'(exp[W]));
        end

        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_sum_retained", 32'(sum), 32'(exp[W-1:0]));
        check("idle_carry_retained", 32'(carry_out), 32'(exp[W]));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        int           seen_valid;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub_drv   = 1'b0;

        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});
`ifdef ADDSUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
        vecs.push_back('{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0});
`endif

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);

        // Directed table
        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].exp_cout, vecs[i].exp_sum});
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, i % 2, 1'b0);
        end

        // Backpressure: three cycles held in DONE
        exp_q.push_back({1'b0, 16'h3333});
        run_op(16'h1111, 16'h2222, 1'b0, 3, 1'b0);

        // in_valid pulsed with a=0x1234 during RUN must be ignored
        exp_q.push_back({1'b0, 16'h0300});
        run_op(16'h0100, 16'h0200, 1'b0, 1, 1'b1);

        // Reset in the second RUN cycle aborts the operation
        a        = 16'hAAAA;
        b        = 16'h1111;
        sub_drv  = 1'b0;
        in_valid = 1'b1;
        step();                     // accept
        in_valid = 1'b0;
        step();                     // now in second RUN cycle
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        seen_valid = 0;
        for (int i = 0; i < NS + 3; i++) begin
            if (out_valid) seen_valid++;
            step();
        end
        check("aborted_never_presented", 32'(seen_valid), 32'd0);
        exp_q.push_back({1'b0, 16'h0007});
        run_op(16'h0003, 16'h0004, 1'b0, 0, 1'b0);

        // Randomized operations against the model
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            if (n % 5 == 0) rb = ~ra;
            if (n % 7 == 0) rb = W'($urandom_range(0, 15));
`ifdef ADDSUB_EN
            rs = 1'($urandom_range(0, 1));
            if (n % 9 == 0) rb = ra;
`else
            rs = 1'b0;
`endif
            exp_q.push_back(model(ra, rb, rs));
            run_op(ra, rb, rs, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 required 0");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_adder_seq_ctrl
